// File: rtl/multicycle_core.sv
// multicycle_core: fetch / decode / execute / writeback engine with an 8-op ALU,
// a zero register, a retire strobe and a terminal HALTED state.
module multicycle_core #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] alu_result,
  output logic            retire_valid,
  output logic            halted
);

  localparam int unsigned RW   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned IMMW = 14;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALTED    = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLT  = 3'd5,
    OP_ADDI = 3'd6,
    OP_HALT = 3'd7
  } op_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic            req_q, req_d;
  logic            retire_q, retire_d;
  logic            halted_q, halted_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  op_e             op_c;
  logic [RW-1:0]   rd_c, rs1_c, rs2_c;
  logic [XLEN-1:0] imm_c;
  logic [XLEN-1:0] alu_c;

  // Instruction field decode from the latched instruction word
  always_comb begin
    op_c  = op_e'(instr_q[31:29]);
    rd_c  = instr_q[24 +: RW];
    rs1_c = instr_q[19 +: RW];
    rs2_c = instr_q[14 +: RW];
    imm_c = {{(XLEN-IMMW){instr_q[IMMW-1]}}, instr_q[IMMW-1:0]};
  end

  // ALU: modulo-2^XLEN arithmetic, SLT is a signed compare
  always_comb begin
    alu_c = '0;
    case (op_c)
      OP_ADD:  alu_c = opa_q + opb_q;
      OP_SUB:  alu_c = opa_q - opb_q;
      OP_AND:  alu_c = opa_q & opb_q;
      OP_OR:   alu_c = opa_q | opb_q;
      OP_XOR:  alu_c = opa_q ^ opb_q;
      OP_SLT:  alu_c = ($signed(opa_q) < $signed(opb_q)) ? XLEN'(1) : '0;
      OP_ADDI: alu_c = opa_q + imm_c;
      default: alu_c = '0;
    endcase
  end

  // Next-state and datapath updates; outputs are registered from the next state
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    alu_d    = alu_q;
    regs_d   = regs_q;

    case (state_q)
      S_FETCH: begin
        // A ready seen while no request is outstanding is not an acceptance
        if (req_q && imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opa_d   = regs_q[rs1_c];
        opb_d   = regs_q[rs2_c];
        state_d = (op_c == OP_HALT) ? S_HALTED : S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_d   = alu_c;
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        if (rd_c != '0) begin
          regs_d[rd_c] = alu_q;
        end
        pc_d    = pc_q + XLEN'(4);
        state_d = S_FETCH;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    req_d    = (state_d == S_FETCH);
    retire_d = (state_d == S_WRITEBACK) ||
               ((state_d == S_HALTED) && (state_q != S_HALTED));
    halted_d = (state_d == S_HALTED);
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      alu_q    <= '0;
      req_q    <= 1'b0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      alu_q    <= alu_d;
      req_q    <= req_d;
      retire_q <= retire_d;
      halted_q <= halted_d;
    end
  end

  // Architectural register file; entry 0 is never written so it reads zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign alu_result   = alu_q;
  assign retire_valid = retire_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: two instances (32b/32 regs and 16b/8 regs) run the
// same program image against an instruction-level reference model.
module tb_multicycle_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ready;
  logic [31:0] prog [64];

  logic        req_a, rv_a, halt_a;
  logic [31:0] addr_a, pc_a, alu_a, rdata_a;
  logic        req_b, rv_b, halt_b;
  logic [15:0] addr_b, pc_b, alu_b;
  logic [31:0] rdata_b;

  assign rdata_a = prog[addr_a[7:2]];
  assign rdata_b = prog[addr_b[7:2]];

  multicycle_core u_dut_a (
    .clk(clk), .reset(reset),
    .imem_req(req_a), .imem_addr(addr_a), .imem_ready(ready), .imem_rdata(rdata_a),
    .pc(pc_a), .alu_result(alu_a), .retire_valid(rv_a), .halted(halt_a)
  );

  multicycle_core #(.XLEN(16), .NREGS(8)) u_dut_b (
    .clk(clk), .reset(reset),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ready(ready), .imem_rdata(rdata_b),
    .pc(pc_b), .alu_result(alu_b), .retire_valid(rv_b), .halted(halt_b)
  );

  // Uniform 64-bit view of both instances
  logic [63:0] o_pc [2], o_alu [2], o_addr [2], o_req [2], o_rv [2], o_halt [2];
  always_comb begin
    o_pc[0] = 64'(pc_a);    o_pc[1] = 64'(pc_b);
    o_alu[0] = 64'(alu_a);  o_alu[1] = 64'(alu_b);
    o_addr[0] = 64'(addr_a); o_addr[1] = 64'(addr_b);
    o_req[0] = 64'(req_a);  o_req[1] = 64'(req_b);
    o_rv[0] = 64'(rv_a);    o_rv[1] = 64'(rv_b);
    o_halt[0] = 64'(halt_a); o_halt[1] = 64'(halt_b);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state (instruction-level, no pipeline/FSM notion)
  int          xl [2] = '{32, 16};
  int          nr [2] = '{32, 8};
  logic [63:0] mregs [2][32];
  logic [63:0] mpc [2];
  logic [63:0] mlast [2];
  bit          mhalt [2];
  logic [63:0] rt_alu0 [$];
  logic [63:0] rt_alu1 [$];
  int          rt_cyc [$];
  int          cyc;
  int          stall_lo = -1;
  int          stall_hi = -1;

  function automatic logic [63:0] msk(input int w, input logic [63:0] v);
    return v & ((64'd1 << xl[w]) - 64'd1);
  endfunction

  function automatic logic signed [63:0] sx(input int w, input logic [63:0] v);
    int s = 64 - xl[w];
    return $signed(v << s) >>> s;
  endfunction

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    return {3'(op), 5'(rd), 5'(rs1), 5'(rs2), 14'(imm)};
  endfunction

  function automatic logic [63:0] qa(input int w, input int i);
    if (w == 0) return (i < rt_alu0.size()) ? rt_alu0[i] : 64'hx;
    return (i < rt_alu1.size()) ? rt_alu1[i] : 64'hx;
  endfunction

  function automatic logic [63:0] qc(input int i);
    return (i < rt_cyc.size()) ? 64'(rt_cyc[i]) : 64'hx;
  endfunction

  function automatic logic next_ready(input int c, input int pct);
    if (c >= stall_lo && c <= stall_hi) return 1'b0;
    if (pct == 0) return 1'b1;
    return ($urandom_range(99) >= pct);
  endfunction

  // Execute one instruction of the model on a retire pulse and compare
  task automatic model_retire(input int w);
    logic [31:0] ins;
    int op, rd, rs1, rs2;
    logic [63:0] a, b, imm, res;
    if (mhalt[w]) begin
      check($sformatf("extra_retire%0d", w), 64'd1, 64'd0);
      return;
    end
    ins = prog[int'((mpc[w] >> 2) & 64'd63)];
    op  = int'(ins[31:29]);
    rd  = int'(ins[28:24]) % nr[w];
    rs1 = int'(ins[23:19]) % nr[w];
    rs2 = int'(ins[18:14]) % nr[w];
    a   = mregs[w][rs1];
    b   = mregs[w][rs2];
    imm = msk(w, 64'($signed(ins[13:0])));
    if (w == 0) rt_cyc.push_back(cyc);
    if (op == 7) begin
      check($sformatf("halt_alu%0d", w), o_alu[w], mlast[w]);
      mhalt[w] = 1'b1;
      if (w == 0) rt_alu0.push_back(o_alu[w]); else rt_alu1.push_back(o_alu[w]);
      return;
    end
    case (op)
      0: res = a + b;
      1: res = a - b;
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (sx(w, a) < sx(w, b)) ? 64'd1 : 64'd0;
      default: res = a + imm;
    endcase
    res = msk(w, res);
    check($sformatf("alu%0d@%0h", w, mpc[w]), o_alu[w], res);
    if (w == 0) rt_alu0.push_back(o_alu[w]); else rt_alu1.push_back(o_alu[w]);
    if (rd != 0) mregs[w][rd] = res;
    mlast[w] = res;
    mpc[w]   = msk(w, mpc[w] + 64'd4);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 32; i++) mregs[w][i] = '0;
      mpc[w] = '0; mlast[w] = '0; mhalt[w] = 1'b0;
    end
    rt_alu0.delete(); rt_alu1.delete(); rt_cyc.delete();
    @(negedge clk);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check($sformatf("rst_pc%0d", w), o_pc[w], 64'd0);
      check($sformatf("rst_alu%0d", w), o_alu[w], 64'd0);
      check($sformatf("rst_req%0d", w), o_req[w], 64'd0);
      check($sformatf("rst_rv%0d", w), o_rv[w], 64'd0);
      check($sformatf("rst_halt%0d", w), o_halt[w], 64'd0);
    end
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Run until both cores halt plus 20 idle cycles, or abort at a given cycle
  task automatic run(input int budget, input int pct, input int abort_cyc);
    int          hcnt = 0;
    bit          done = 1'b0;
    logic [63:0] pr_req [2];
    logic [63:0] pr_addr [2];
    logic        pready;
    ready  = next_ready(1, pct);
    pready = ready;
    for (int w = 0; w < 2; w++) begin
      pr_req[w] = o_req[w]; pr_addr[w] = o_addr[w];
    end
    while (!done && cyc < budget) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == abort_cyc) return;
      for (int w = 0; w < 2; w++) begin
        check($sformatf("pc%0d", w), o_pc[w], mpc[w]);
        if (pr_req[w] == 64'd1 && !pready) begin
          check($sformatf("stall_req%0d", w), o_req[w], 64'd1);
          check($sformatf("stall_addr%0d", w), o_addr[w], pr_addr[w]);
        end
        if (o_rv[w] == 64'd1) model_retire(w);
        check($sformatf("halted%0d", w), o_halt[w], 64'(mhalt[w]));
        if (mhalt[w]) check($sformatf("halt_req%0d", w), o_req[w], 64'd0);
        pr_req[w]  = o_req[w];
        pr_addr[w] = o_addr[w];
      end
      if (mhalt[0] && mhalt[1]) begin
        hcnt++;
        if (hcnt > 20) done = 1'b1;
      end
      ready  = (mhalt[0] && mhalt[1]) ? 1'b1 : next_ready(cyc + 1, pct);
      pready = ready;
    end
    if (!done) check("timeout", 64'd0, 64'd1);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = enc(7, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    clear_prog();

    // Basic ALU program, imem_ready tied high
    prog[0] = enc(6, 1, 0, 0, 5);
    prog[1] = enc(6, 2, 0, 0, 7);
    prog[2] = enc(0, 3, 1, 2, 0);
    prog[3] = enc(1, 4, 1, 2, 0);
    prog[4] = enc(5, 5, 1, 2, 0);
    prog[5] = enc(5, 5, 2, 1, 0);
    prog[6] = enc(6, 0, 0, 0, 9);
    prog[7] = enc(0, 6, 0, 0, 0);
    prog[8] = enc(0, 7, 3, 0, 0);
    do_reset();
    run(400, 0, -1);
    check("rt_cyc0", qc(0), 64'd4);
    check("rt_cyc1", qc(1), 64'd8);
    check("rt_cyc2", qc(2), 64'd12);
    check("add_r3", qa(0, 2), 64'd12);
    check("sub32", qa(0, 3), 64'hFFFF_FFFE);
    check("sub16", qa(1, 3), 64'hFFFE);
    check("slt_lt", qa(0, 4), 64'd1);
    check("slt_ge", qa(0, 5), 64'd0);
    check("r0_add", qa(0, 7), 64'd0);
    check("r3_read", qa(0, 8), 64'd12);

    // Fetch stall of three cycles, then HALT at pc 0x10
    clear_prog();
    prog[0] = enc(6, 1, 0, 0, 5);
    prog[1] = enc(6, 2, 1, 0, 2);
    prog[2] = enc(4, 3, 1, 2, 0);
    prog[3] = enc(3, 4, 1, 2, 0);
    do_reset();
    stall_lo = 6; stall_hi = 8;
    run(400, 0, -1);
    stall_lo = -1; stall_hi = -1;
    check("stall_rt0", qc(0), 64'd4);
    check("stall_rt1", qc(1), 64'd11);
    check("stall_alu", qa(0, 1), 64'd7);
    check("halt_pc", o_pc[0], 64'h10);
    check("halt_nret", 64'(rt_cyc.size()), 64'd5);

    // Reset during EXECUTE of ADDI r1,r0,3
    clear_prog();
    prog[0] = enc(6, 2, 0, 0, 9);
    prog[1] = enc(6, 1, 0, 0, 3);
    prog[2] = enc(0, 3, 1, 0, 0);
    do_reset();
    run(400, 0, 7);
    reset = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) begin
      check($sformatf("mid_req%0d", w), o_req[w], 64'd0);
      check($sformatf("mid_pc%0d", w), o_pc[w], 64'd0);
      check($sformatf("mid_alu%0d", w), o_alu[w], 64'd0);
    end
    prog[1] = enc(0, 3, 1, 0, 0);
    prog[2] = enc(7, 0, 0, 0, 0);
    do_reset();
    run(400, 0, -1);
    check("r1_after_rst", qa(0, 1), 64'd0);

    // Wrap-around and narrow register indices
    clear_prog();
    prog[0]  = enc(6, 1, 0, 0, 14'h1FFF);
    prog[1]  = enc(0, 1, 1, 1, 0);
    prog[2]  = enc(0, 1, 1, 1, 0);
    prog[3]  = enc(6, 1, 1, 0, 3);
    prog[4]  = enc(6, 2, 1, 0, 1);
    prog[5]  = enc(0, 4, 2, 2, 0);
    prog[6]  = enc(6, 9, 0, 0, 14'h11);
    prog[7]  = enc(0, 11, 1, 0, 0);
    prog[8]  = enc(6, 5, 0, 0, 14'h3FFF);
    prog[9]  = enc(5, 6, 5, 0, 0);
    do_reset();
    run(400, 20, -1);
    check("wrap16", qa(1, 4), 64'h8000);
    check("wrap16_add", qa(1, 5), 64'h0);
    check("nowrap32", qa(0, 5), 64'h1_0000);
    check("idx16", qa(1, 7), 64'h11);
    check("idx32", qa(0, 7), 64'h7FFF);
    check("neg16", qa(1, 8), 64'hFFFF);
    check("slt_neg", qa(1, 9), 64'd1);

    // Random programs, with and without fetch stalls
    for (int t = 0; t < 4; t++) begin
      clear_prog();
      for (int i = 0; i < 30; i++) begin
        prog[i] = enc(int'($urandom_range(6)), int'($urandom_range(9)),
                      int'($urandom_range(9)), int'($urandom_range(9)),
                      int'($urandom_range(16383)));
      end
      do_reset();
      run(2000, (t % 2) * 35, -1);
      check($sformatf("rand_nret%0d", t), 64'(rt_cyc.size()), 64'd31);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
